// File: rtl/qtime_pkg.sv
// Shared timing/codeword definitions for quantum_ctrl, timed_event_queue and the codeword output stage.
package qtime_pkg;

  localparam int QT_TIME_W = 20;
  localparam int QT_CW_W   = 18;
  localparam int QT_DEPTH  = 32;

  typedef struct packed {
    logic [QT_TIME_W-1:0] stamp;
    logic [QT_CW_W-1:0]   cw;
  } teq_entry_t;

endpackage

// File: rtl/timed_event_queue_if.sv
// Push/event bus of one timed_event_queue channel; master = producer/consumer side, slave = queue.
interface timed_event_queue_if
  import qtime_pkg::*;
#(
  parameter int DEPTH  = QT_DEPTH,
  parameter int TIME_W = QT_TIME_W,
  parameter int CW_W   = QT_CW_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [TIME_W-1:0] abs_time;
  logic [CW_W-1:0]   wd;
  logic              ev_valid;
  logic [CW_W-1:0]   ev_data;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              ovf_err;
  logic              late_err;

  modport master (
    output wr_en, abs_time, wd,
    input  ev_valid, ev_data, full, empty, count, ovf_err, late_err
  );

  modport slave (
    input  wr_en, abs_time, wd,
    output ev_valid, ev_data, full, empty, count, ovf_err, late_err
  );

endinterface

// File: rtl/teq_ram.sv
// Entry storage for timed_event_queue: registered write port, asynchronous read port.
module teq_ram
  import qtime_pkg::*;
#(
  parameter int DEPTH = QT_DEPTH,
  parameter int W     = QT_TIME_W + QT_CW_W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write port; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/timed_event_queue.sv
// Per-channel timestamped event FIFO: fires each codeword as a one-cycle strobe when t_cnt meets its stamp.
// Optional macro TEQ_LATE_DROP_EN: drop overdue heads and raise late_err instead of firing them.
module timed_event_queue
  import qtime_pkg::*;
#(
  parameter int DEPTH  = QT_DEPTH,
  parameter int TIME_W = QT_TIME_W,
  parameter int CW_W   = QT_CW_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [TIME_W-1:0]  t_cnt,
  timed_event_queue_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   ev_valid_r;
  logic [CW_W-1:0]        ev_data_r;
  logic                   ovf_err_r;
  logic                   late_err_r;
  logic [TIME_W+CW_W-1:0] head_s;
  logic [TIME_W-1:0]      head_time_s;
  logic [CW_W-1:0]        head_cw_s;
  logic [TIME_W-1:0]      diff_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   fire_s;
  logic                   drop_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   ovf_s;

  teq_ram #(
    .DEPTH (DEPTH),
    .W     (TIME_W + CW_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata ({bus.abs_time, bus.wd}),
    .raddr (rd_ptr_r),
    .rdata (head_s)
  );

  assign head_time_s = head_s[TIME_W+CW_W-1:CW_W];
  assign head_cw_s   = head_s[CW_W-1:0];
  // Modular difference: MSB set means the head stamp is already in the past.
  assign diff_s      = head_time_s - t_cnt;
  assign full_s      = (count_r == CNT_DEPTH);
  assign empty_s     = (count_r == {CNT_W{1'b0}});

  // Head disposition: fire when due, overdue handling selected at build time.
  always_comb begin
    fire_s = 1'b0;
    drop_s = 1'b0;
    if (!empty_s) begin
      if (diff_s == {TIME_W{1'b0}}) begin
        fire_s = 1'b1;
      end else if (diff_s[TIME_W-1]) begin
`ifdef TEQ_LATE_DROP_EN
        drop_s = 1'b1;
`else
        fire_s = 1'b1;
`endif
      end else begin
        fire_s = 1'b0;
      end
    end else begin
      fire_s = 1'b0;
    end
  end

  assign pop_s  = fire_s | drop_s;
  assign push_s = bus.wr_en & (~full_s | pop_s);
  assign ovf_s  = bus.wr_en & full_s & ~pop_s;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered event strobe; data holds the last released codeword.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_valid_r <= 1'b0;
      ev_data_r  <= {CW_W{1'b0}};
    end else begin
      ev_valid_r <= fire_s;
      if (fire_s) begin
        ev_data_r <= head_cw_s;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_err_r  <= 1'b0;
      late_err_r <= 1'b0;
    end else begin
      ovf_err_r  <= ovf_err_r | ovf_s;
      late_err_r <= late_err_r | drop_s;
    end
  end

  assign bus.ev_valid = ev_valid_r;
  assign bus.ev_data  = ev_data_r;
  assign bus.full     = full_s;
  assign bus.empty    = empty_s;
  assign bus.count    = count_r;
  assign bus.ovf_err  = ovf_err_r;
  assign bus.late_err = late_err_r;

endmodule

// File: tb/tb_timed_event_queue.sv
// Self-checking bench for timed_event_queue: directed vectors, corner sequences and a randomized FIFO model.
module tb_timed_event_queue;
  import qtime_pkg::*;

  localparam int DEPTH  = 32;
  localparam int TIME_W = 20;
  localparam int CW_W   = 18;

  typedef struct {
    logic [TIME_W-1:0] t;
    logic [CW_W-1:0]   d;
  } obs_t;

  typedef struct {
    logic [TIME_W-1:0] t0;
    logic [TIME_W-1:0] stamp;
    logic [CW_W-1:0]   cw;
    int                exp_fires;
    logic [TIME_W-1:0] exp_t;
    logic              exp_late;
  } vec_t;

  logic              clk;
  logic              reset;
  logic [TIME_W-1:0] t_cnt;

  timed_event_queue_if #(.DEPTH(DEPTH), .TIME_W(TIME_W), .CW_W(CW_W)) bus ();

  timed_event_queue #(.DEPTH(DEPTH), .TIME_W(TIME_W), .CW_W(CW_W)) dut (
    .clk   (clk),
    .reset (reset),
    .t_cnt (t_cnt),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int peak     = 0;
  obs_t obs[$];

  // Reference model: an ordered list of pending entries plus the visible outputs.
  teq_entry_t        mq[$];
  logic              m_ev_valid;
  logic [CW_W-1:0]   m_ev_data;
  logic              m_ovf;
  logic              m_late;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t_cnt=%0h)", name, act, exp, t_cnt);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ev_valid = 1'b0;
    m_ev_data  = '0;
    m_ovf      = 1'b0;
    m_late     = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic [TIME_W-1:0] st, input logic [CW_W-1:0] c);
    int unsigned d;
    logic fire, drop;
    teq_entry_t e;
    fire = 1'b0;
    drop = 1'b0;
    if (mq.size() > 0) begin
      d = (32'(mq[0].stamp) + 32'h0010_0000 - 32'(t_cnt)) & 32'h000F_FFFF;
      if (d == 0) fire = 1'b1;
      else if (d >= 32'h0008_0000) begin
`ifdef TEQ_LATE_DROP_EN
        drop = 1'b1;
`else
        fire = 1'b1;
`endif
      end
    end
    if (fire) m_ev_data = mq[0].cw;
    if (fire || drop) void'(mq.pop_front());
    if (drop) m_late = 1'b1;
    m_ev_valid = fire;
    if (w) begin
      if (mq.size() < DEPTH) begin
        e.stamp = st;
        e.cw    = c;
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("ev_valid", 32'(bus.ev_valid), 32'(m_ev_valid));
    chk("ev_data",  32'(bus.ev_data),  32'(m_ev_data));
    chk("count",    32'(bus.count),    32'(mq.size()));
    chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
    chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
    chk("ovf_err",  32'(bus.ovf_err),  32'(m_ovf));
    chk("late_err", 32'(bus.late_err), 32'(m_late));
    if (bus.ev_valid) obs.push_back('{t: t_cnt, d: bus.ev_data});
    if (int'(bus.count) > peak) peak = int'(bus.count);
  endtask

  task automatic cycle(input logic w, input logic [TIME_W-1:0] st, input logic [CW_W-1:0] c);
    bus.wr_en    = w;
    bus.abs_time = st;
    bus.wd       = c;
    model_step(w, st, c);
    @(posedge clk);
    #1;
    t_cnt = t_cnt + 20'd1;
    bus.wr_en = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    bus.wr_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    t_cnt = t_cnt + 20'd1;
    reset = 1'b0;
    check_outputs();
  endtask

  task automatic chk_obs(input string name, input int idx, input logic [TIME_W-1:0] et, input logic [CW_W-1:0] ed);
    if (obs.size() > idx) begin
      chk({name, "_time"}, 32'(obs[idx].t), 32'(et));
      chk({name, "_data"}, 32'(obs[idx].d), 32'(ed));
    end else begin
      chk({name, "_present"}, 32'(obs.size()), 32'(idx + 1));
    end
  endtask

  vec_t vecs[6];

  initial begin
    reset        = 1'b1;
    t_cnt        = '0;
    bus.wr_en    = 1'b0;
    bus.abs_time = '0;
    bus.wd       = '0;

    vecs[0] = '{t0: 20'd100,     stamp: 20'd105,     cw: 18'h000A5, exp_fires: 1, exp_t: 20'd106,     exp_late: 1'b0};
    vecs[1] = '{t0: 20'hFFFFE,   stamp: 20'h00003,   cw: 18'h3FFFF, exp_fires: 1, exp_t: 20'h00004,   exp_late: 1'b0};
    vecs[2] = '{t0: 20'd500,     stamp: 20'd501,     cw: 18'h12345, exp_fires: 1, exp_t: 20'd502,     exp_late: 1'b0};
    vecs[3] = '{t0: 20'h7FFF0,   stamp: 20'h80018,   cw: 18'h2AAAA, exp_fires: 1, exp_t: 20'h80019,   exp_late: 1'b0};
`ifdef TEQ_LATE_DROP_EN
    vecs[4] = '{t0: 20'd60,      stamp: 20'd50,      cw: 18'h00050, exp_fires: 0, exp_t: 20'd0,       exp_late: 1'b1};
    vecs[5] = '{t0: 20'd1000,    stamp: 20'd1000,    cw: 18'h03E8,  exp_fires: 0, exp_t: 20'd0,       exp_late: 1'b1};
`else
    vecs[4] = '{t0: 20'd60,      stamp: 20'd50,      cw: 18'h00050, exp_fires: 1, exp_t: 20'd62,      exp_late: 1'b0};
    vecs[5] = '{t0: 20'd1000,    stamp: 20'd1000,    cw: 18'h003E8, exp_fires: 1, exp_t: 20'd1002,    exp_late: 1'b0};
`endif

    // Single-push vectors: fire time, pulse count and late flag.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      t_cnt = vecs[v].t0;
      obs.delete();
      cycle(1'b1, vecs[v].stamp, vecs[v].cw);
      idle(60);
      chk($sformatf("vec%0d_fires", v), 32'(obs.size()), 32'(vecs[v].exp_fires));
      if (vecs[v].exp_fires > 0) chk_obs($sformatf("vec%0d", v), 0, vecs[v].exp_t, vecs[v].cw);
      chk($sformatf("vec%0d_late", v), 32'(bus.late_err), 32'(vecs[v].exp_late));
      chk($sformatf("vec%0d_count", v), 32'(bus.count), 32'd0);
    end

    // Three ordered stamps pushed back to back.
    do_reset();
    t_cnt = 20'd150;
    obs.delete();
    peak = 0;
    cycle(1'b1, 20'd200, 18'h00011);
    cycle(1'b1, 20'd210, 18'h00022);
    cycle(1'b1, 20'd220, 18'h00033);
    idle(80);
    chk("three_n", 32'(obs.size()), 32'd3);
    chk_obs("three0", 0, 20'd201, 18'h00011);
    chk_obs("three1", 1, 20'd211, 18'h00022);
    chk_obs("three2", 2, 20'd221, 18'h00033);
    chk("three_peak", 32'(peak), 32'd3);

    // Equal stamps: the second one reaches the head after its time has passed.
    do_reset();
    t_cnt = 20'd400;
    obs.delete();
    cycle(1'b1, 20'd405, 18'h00AAA);
    cycle(1'b1, 20'd405, 18'h00BBB);
    idle(20);
    chk_obs("dup0", 0, 20'd406, 18'h00AAA);
`ifdef TEQ_LATE_DROP_EN
    chk("dup_n", 32'(obs.size()), 32'd1);
    chk("dup_late", 32'(bus.late_err), 32'd1);
`else
    chk("dup_n", 32'(obs.size()), 32'd2);
    chk_obs("dup1", 1, 20'd407, 18'h00BBB);
    chk("dup_late", 32'(bus.late_err), 32'd0);
`endif

    // Fill to DEPTH, overflow once, then drain in order.
    do_reset();
    t_cnt = 20'd1000;
    obs.delete();
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 20'(2000 + i), 18'(18'h00100 + i));
    chk("fill_count", 32'(bus.count), 32'd32);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_ovf", 32'(bus.ovf_err), 32'd1);
    idle(1010);
    chk("fill_n", 32'(obs.size()), 32'd32);
    chk_obs("fill_first", 0, 20'd2001, 18'h00100);
    chk_obs("fill_last", 31, 20'd2032, 18'h0011F);

    // Reset with future entries pending flushes them.
    do_reset();
    t_cnt = 20'd300;
    for (int i = 0; i < 5; i++) cycle(1'b1, 20'(310 + i), 18'(18'h00C00 + i));
    chk("flush_pre_count", 32'(bus.count), 32'd5);
    do_reset();
    obs.delete();
    idle(30);
    chk("flush_events", 32'(obs.size()), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_count", 32'(bus.count), 32'd0);

    // Randomized traffic against the model, including late stamps, duplicates and rare resets.
    do_reset();
    t_cnt = 20'($urandom);
    begin
      logic [TIME_W-1:0] last_st;
      logic [TIME_W-1:0] st;
      int r;
      last_st = t_cnt + 20'd5;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 499) == 0) begin
          do_reset();
        end else if ($urandom_range(0, 99) < 60) begin
          r = int'($urandom_range(0, 99));
          if (r < 70)      st = t_cnt + 20'($urandom_range(1, 80));
          else if (r < 80) st = t_cnt - 20'($urandom_range(1, 10));
          else if (r < 90) st = last_st;
          else             st = t_cnt;
          last_st = st;
          cycle(1'b1, st, 18'($urandom));
        end else begin
          cycle(1'b0, '0, '0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timed_event_queue.md
# timed_event_queue

Per-channel timestamped event buffer downstream of `quantum_ctrl`; one instance per channel (NCH instances) consumes `abs_time`/`fifo_wr_en`/`fifo_wd` slices. Stores {timestamp, codeword} entries in order. Releases each codeword as a one-cycle event when the free-running `t_cnt` reaches its timestamp. Flags overflow and (optionally) late events onto the channel's error path.

## Interface
- `DEPTH`, 32, entry count; power of two, ≥2
- `TIME_W`, 20, timestamp and `t_cnt` width
- `CW_W`, 18, codeword width
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `t_cnt`  in  TIME_W  free-running timer, increments by 1 per cycle, wraps
- `wr_en`  in  1  push request (from `fifo_wr_en[ch]`)
- `abs_time`  in  TIME_W  push timestamp (from `abs_time[ch]` slice)
- `wd`  in  CW_W  push codeword (from `fifo_wd[ch]` slice)
- `ev_valid`  out  1  one-cycle event strobe
- `ev_data`  out  CW_W  codeword of released event; holds last value when `ev_valid`=0
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  $clog2(DEPTH+1)  occupancy
- `ovf_err`  out  1  sticky: push dropped while full
- `late_err`  out  1  sticky: overdue head dropped (0 when feature compiled out)

## Operation
- Storage: circular buffer, read/write pointers of $clog2(DEPTH) bits, wrap naturally; `count` tracked separately.
- Push: `wr_en` & (!full | pop this cycle) → entry written at wr_ptr, wr_ptr+1. `wr_en` & full & no pop → entry dropped, `ovf_err` set.
- Head compare: `diff` = signed(head_time − t_cnt) in TIME_W bits, modular. Valid future window: diff in [0, 2^(TIME_W−1)−1].
- Due: head present & diff == 0 → pop; next cycle `ev_valid`=1, `ev_data`=head codeword.
- Overdue (diff < 0): behaviour per Configuration.
- At most one pop per cycle; push and pop in same cycle allowed at any occupancy, `count` unchanged.
- Equal timestamps back-to-back: first fires on match; second reaches head after `t_cnt` has moved → overdue.
- Reset: pointers, count cleared; `ev_valid`, `ev_data`, `ovf_err`, `late_err` = 0; `empty`=1, `full`=0. Reset mid-operation flushes all entries; no events released from flushed data.

## Timing
- Push-to-head: entry written at edge N is eligible for compare in cycle N+1 (no bypass into empty queue).
- Scheduling rule for producer: stamp ≥ t_cnt(at push)+1 to be on time.
- Fire latency: `ev_valid` high in the cycle where `t_cnt` == stamp+1 (registered output).
- `full`/`empty`/`count` reflect state after the most recent edge.
- Sticky flags assert the cycle after the causing event, clear only on `reset`.

## Configuration
- `TEQ_LATE_DROP_EN` defined: overdue head (diff < 0) popped without `ev_valid`, `late_err` set; one drop per cycle.
- Undefined: overdue head treated as due (fires when diff ≤ 0), emitted with normal latency; `late_err` tied 0.

## Structure
- Shared package `qtime_pkg`: `TIME_W`, `CW_W` defaults, `teq_entry_t` packed struct {time, cw}, shared with `quantum_ctrl` and the AWG/codeword output stage.
- Sub-module `teq_ram`: DEPTH×(TIME_W+CW_W) storage with registered write, asynchronous read at rd_ptr; control/compare logic in top.

## Test plan
- Reset then t_cnt=100, push {105, 18'h00A5} → `ev_valid`=1 with `ev_data`=18'h00A5 when t_cnt=106, exactly one cycle; `count` back to 0.
- Push stamps 200, 210, 220 in consecutive cycles at t_cnt=150 → three events at t_cnt 201, 211, 221, in order; `count` peaks at 3.
- Fill 32 entries, push 33rd with no pop → dropped, `ovf_err`=1, `full`=1, `count`=32; entry 1 still fires first.
- Wrap: t_cnt=20'hFFFFE, push stamp 20'h00003 → event at t_cnt=20'h00004; no late flag.
- Push stamp 50 at t_cnt=60: with `TEQ_LATE_DROP_EN` → no event, `late_err`=1; without → event at t_cnt=62, `late_err`=0.
- Load 5 future entries, assert `reset` one cycle → `empty`=1, `count`=0, no `ev_valid` at their stamps.
